// File: rtl/load_store_buffer.sv
// -----------------------------------------------------------------------------
// load_store_buffer
//   In-order load/store queue between the ROB and the unified 8-bit memory
//   port. Dispatched memory ops are queued with their operands. Each pending
//   operand tag snoops the ALU broadcast and this block's own completion
//   broadcast. The head op is offered to the ROB on ready_load_num. Once
//   ls_commit names it, the op runs a little-endian byte-serial access and
//   then pulses its result on mem_num/mem_value.
//
// Optional feature macro: LSB_MISALIGN_CHECK_EN
//   When defined, adds output misalign_err. Misaligned halfword/word ops
//   complete immediately with mem_value=0 and misalign_err=1. They make no
//   memory access.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   op_in             dispatched op (5'b11111 = none, LB..SW accepted)
//   value1_in/query1  base address operand / producing ROB tag (0 = ready)
//   value2_in/query2  store data operand / producing ROB tag (0 = ready)
//   imm_in            address offset
//   target_in         ROB tag of the dispatched op
//   alu_num/alu_value ALU result broadcast (tag 0 = none)
//   ls_commit/ls_num  ROB permission for the head op
//   mem_din           read byte, valid the cycle after its address
//   lsb_full          registered; queue has at most one free slot
//   ready_load_num    tag of the resolved head op awaiting commit
//   mem_num/mem_value completion pulse and result
//   mem_a/mem_dout/mem_wr  byte-serial memory port
// -----------------------------------------------------------------------------
module load_store_buffer #(
  parameter int LSB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  target_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic        ls_commit,
  input  logic [2:0]  ls_num,
  input  logic [7:0]  mem_din,
  output logic        lsb_full,
  output logic [2:0]  ready_load_num,
  output logic [2:0]  mem_num,
  output logic [31:0] mem_value,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr
`ifdef LSB_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int PTR_W = $clog2(LSB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSB_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(LSB_DEPTH - 1);

  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SH  = 5'b11000;
  localparam logic [4:0] OP_SW  = 5'b11001;

  // state        | meaning
  // S_IDLE        | waiting for a valid head with all needed operands
  // S_WAIT_COMMIT | head advertised on ready_load_num, waiting for ls_commit
  // S_ACCESS      | byte-serial memory access (loads add one capture cycle)
  // S_DONE        | completion pulse on mem_num; head entry retired
  typedef enum logic [1:0] {S_IDLE, S_WAIT_COMMIT, S_ACCESS, S_DONE} state_t;

  function automatic logic [2:0] op_len(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
      default:              op_len = 3'd4;
    endcase
  endfunction

  // Queue storage
  logic        r_valid [LSB_DEPTH];
  logic [4:0]  r_op    [LSB_DEPTH];
  logic [31:0] r_v1    [LSB_DEPTH];
  logic [31:0] r_v2    [LSB_DEPTH];
  logic [31:0] r_imm   [LSB_DEPTH];
  logic [2:0]  r_q1    [LSB_DEPTH];
  logic [2:0]  r_q2    [LSB_DEPTH];
  logic [2:0]  r_tag   [LSB_DEPTH];

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  // Access engine
  state_t      r_state;
  logic [2:0]  r_len;
  logic [2:0]  r_byte_idx;
  logic        r_is_load;
  logic        r_is_signed;
  logic [31:0] r_st_data;
  logic [31:0] r_ld_data;

  logic             w_is_mem_op, w_is_load_in, w_enq, w_deq;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_q1_alu, w_q1_mem, w_q2_alu, w_q2_mem;
  logic [31:0]      w_v1_cap, w_v2_cap;
  logic [2:0]       w_q1_cap, w_q2_cap;
  logic [4:0]       w_head_op;
  logic [2:0]       w_head_tag, w_head_len;
  logic [31:0]      w_head_addr, w_head_data;
  logic             w_head_is_load, w_head_signed, w_head_ready;
  logic             w_misalign;
  logic [2:0]       w_last_idx;
  logic [1:0]       w_prev_idx;
  logic [31:0]      w_ld_bytes, w_ld_ext;

  assign w_is_mem_op  = (op_in >= OP_LB) && (op_in <= OP_SW);
  assign w_is_load_in = (op_in <= OP_LHU);
  assign w_enq        = w_is_mem_op && (r_count < DEPTH_C);
  assign w_deq        = (r_state == S_DONE);

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_deq)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_enq && w_deq)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // Operands resolved in the very cycle they are dispatched
  assign w_q1_alu = (query1_in != 3'd0) && (query1_in == alu_num);
  assign w_q1_mem = (query1_in != 3'd0) && (query1_in == mem_num);
  assign w_q2_alu = (query2_in != 3'd0) && (query2_in == alu_num);
  assign w_q2_mem = (query2_in != 3'd0) && (query2_in == mem_num);

  assign w_v1_cap = w_q1_alu ? alu_value : (w_q1_mem ? mem_value : value1_in);
  assign w_q1_cap = (w_q1_alu || w_q1_mem) ? 3'd0 : query1_in;
  assign w_v2_cap = w_q2_alu ? alu_value : (w_q2_mem ? mem_value : value2_in);
  // Loads never wait on the data operand
  assign w_q2_cap = (w_is_load_in || w_q2_alu || w_q2_mem) ? 3'd0 : query2_in;

  assign w_head_op      = r_op[r_head];
  assign w_head_tag     = r_tag[r_head];
  assign w_head_len     = op_len(w_head_op);
  assign w_head_addr    = r_v1[r_head] + r_imm[r_head];
  assign w_head_data    = r_v2[r_head];
  assign w_head_is_load = (w_head_op <= OP_LHU);
  assign w_head_signed  = (w_head_op == OP_LB) || (w_head_op == OP_LH);
  assign w_head_ready   = r_valid[r_head] && (r_q1[r_head] == 3'd0) &&
                          (w_head_is_load || (r_q2[r_head] == 3'd0));

`ifdef LSB_MISALIGN_CHECK_EN
  assign w_misalign = ((w_head_len == 3'd2) && w_head_addr[0]) ||
                      ((w_head_len == 3'd4) && (w_head_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_last_idx = r_len - 3'd1;
  // Byte index k cycle carries mem_din for byte k-1
  assign w_prev_idx = 2'(r_byte_idx - 3'd1);

  always_comb begin
    w_ld_bytes = r_ld_data;
    w_ld_bytes[{w_prev_idx, 3'b000} +: 8] = mem_din;
    case (r_len)
      3'd1:    w_ld_ext = r_is_signed ? {{24{w_ld_bytes[7]}}, w_ld_bytes[7:0]}
                                      : {24'h0, w_ld_bytes[7:0]};
      3'd2:    w_ld_ext = r_is_signed ? {{16{w_ld_bytes[15]}}, w_ld_bytes[15:0]}
                                      : {16'h0, w_ld_bytes[15:0]};
      default: w_ld_ext = w_ld_bytes;
    endcase
  end

  // Queue: enqueue at tail, retire head on DONE, snoop broadcasts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      lsb_full <= 1'b0;
      for (int i = 0; i < LSB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_op[i]    <= 5'd0;
        r_v1[i]    <= 32'd0;
        r_v2[i]    <= 32'd0;
        r_imm[i]   <= 32'd0;
        r_q1[i]    <= 3'd0;
        r_q2[i]    <= 3'd0;
        r_tag[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < LSB_DEPTH; i++) begin
        if (w_enq && (r_tail == PTR_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_op[i]    <= op_in;
          r_v1[i]    <= w_v1_cap;
          r_q1[i]    <= w_q1_cap;
          r_v2[i]    <= w_v2_cap;
          r_q2[i]    <= w_q2_cap;
          r_imm[i]   <= imm_in;
          r_tag[i]   <= target_in;
        end else if (r_valid[i]) begin
          if (w_deq && (r_head == PTR_W'(i)))
            r_valid[i] <= 1'b0;
          if ((r_q1[i] != 3'd0) && (r_q1[i] == alu_num)) begin
            r_v1[i] <= alu_value;
            r_q1[i] <= 3'd0;
          end else if ((r_q1[i] != 3'd0) && (r_q1[i] == mem_num)) begin
            r_v1[i] <= mem_value;
            r_q1[i] <= 3'd0;
          end
          if ((r_q2[i] != 3'd0) && (r_q2[i] == alu_num)) begin
            r_v2[i] <= alu_value;
            r_q2[i] <= 3'd0;
          end else if ((r_q2[i] != 3'd0) && (r_q2[i] == mem_num)) begin
            r_v2[i] <= mem_value;
            r_q2[i] <= 3'd0;
          end
        end
      end
      if (w_enq)
        r_tail <= r_tail + PTR_W'(1);
      if (w_deq)
        r_head <= r_head + PTR_W'(1);
      r_count  <= w_count_nxt;
      // One slot of slack: dispatch sees full a cycle late
      lsb_full <= (w_count_nxt >= FULL_C);
    end
  end

  // Head sequencing and memory access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      ready_load_num <= 3'd0;
      mem_num        <= 3'd0;
      mem_value      <= 32'd0;
      mem_a          <= 32'd0;
      mem_dout       <= 8'd0;
      mem_wr         <= 1'b0;
      r_len          <= 3'd0;
      r_byte_idx     <= 3'd0;
      r_is_load      <= 1'b0;
      r_is_signed    <= 1'b0;
      r_st_data      <= 32'd0;
      r_ld_data      <= 32'd0;
`ifdef LSB_MISALIGN_CHECK_EN
      misalign_err   <= 1'b0;
`endif
    end else begin
      mem_num   <= 3'd0;
      mem_value <= 32'd0;
`ifdef LSB_MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_head_ready) begin
            r_state        <= S_WAIT_COMMIT;
            ready_load_num <= w_head_tag;
          end
        end
        S_WAIT_COMMIT: begin
          if (ls_commit && (ls_num == w_head_tag)) begin
            ready_load_num <= 3'd0;
            r_len          <= w_head_len;
            r_is_load      <= w_head_is_load;
            r_is_signed    <= w_head_signed;
            r_byte_idx     <= 3'd0;
            r_ld_data      <= 32'd0;
            if (w_misalign) begin
              r_state <= S_DONE;
              mem_num <= w_head_tag;
`ifdef LSB_MISALIGN_CHECK_EN
              misalign_err <= 1'b1;
`endif
            end else begin
              // First byte goes out in the cycle right after commit
              r_state   <= S_ACCESS;
              mem_a     <= w_head_addr;
              mem_wr    <= !w_head_is_load;
              mem_dout  <= w_head_is_load ? 8'd0 : w_head_data[7:0];
              r_st_data <= {8'd0, w_head_data[31:8]};
            end
          end
        end
        S_ACCESS: begin
          if (!r_is_load) begin
            if (r_byte_idx == w_last_idx) begin
              r_state  <= S_DONE;
              mem_num  <= w_head_tag;
              mem_wr   <= 1'b0;
              mem_a    <= 32'd0;
              mem_dout <= 8'd0;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
              mem_a      <= mem_a + 32'd1;
              mem_dout   <= r_st_data[7:0];
              r_st_data  <= {8'd0, r_st_data[31:8]};
            end
          end else begin
            if (r_byte_idx != 3'd0)
              r_ld_data <= w_ld_bytes;
            if (r_byte_idx == r_len) begin
              r_state   <= S_DONE;
              mem_num   <= w_head_tag;
              mem_value <= w_ld_ext;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
              // Trailing cycle only collects the last byte; port goes quiet
              if (r_byte_idx == w_last_idx)
                mem_a <= 32'd0;
              else
                mem_a <= mem_a + 32'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
module tb_load_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  op_in;
  logic [31:0] value1_in, value2_in, imm_in, alu_value;
  logic [2:0]  query1_in, query2_in, target_in, alu_num, ls_num;
  logic        ls_commit;
  logic [7:0]  mem_din;
  logic        lsb_full;
  logic [2:0]  ready_load_num, mem_num;
  logic [31:0] mem_value, mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
`ifdef LSB_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  always #5 clk = ~clk;

  load_store_buffer #(.LSB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .op_in(op_in),
    .value1_in(value1_in), .value2_in(value2_in),
    .query1_in(query1_in), .query2_in(query2_in),
    .imm_in(imm_in), .target_in(target_in),
    .alu_num(alu_num), .alu_value(alu_value),
    .ls_commit(ls_commit), .ls_num(ls_num), .mem_din(mem_din),
    .lsb_full(lsb_full), .ready_load_num(ready_load_num),
    .mem_num(mem_num), .mem_value(mem_value),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
`ifdef LSB_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  // Fixed read contents; write bytes are logged for inspection
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h20:  return 8'h80;
      32'h30:  return 8'h01;
      32'h31:  return 8'h02;
      32'h32:  return 8'h03;
      32'h33:  return 8'h04;
      32'h34:  return 8'h05;
      32'h48:  return 8'hDE;
      32'h49:  return 8'hAD;
      32'h4A:  return 8'hBE;
      32'h4B:  return 8'hEF;
      32'h101: return 8'h34;
      32'h102: return 8'h92;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_din <= mem_rd(mem_a);
    if (mem_wr) begin
      wr_addr_q.push_back(mem_a);
      wr_data_q.push_back(mem_dout);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic dispatch(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [2:0] q1, input logic [2:0] q2,
                          input logic [31:0] imm, input logic [2:0] tag);
    op_in = op; value1_in = v1; value2_in = v2; query1_in = q1; query2_in = q2;
    imm_in = imm; target_in = tag;
    @(negedge clk);
    op_in = 5'h1F; query1_in = 3'd0; query2_in = 3'd0;
  endtask

  task automatic wait_ready(input logic [2:0] tag, output bit ok);
    int i;
    ok = 0;
    i = 0;
    while (!ok && i < 20) begin
      if (ready_load_num == tag) ok = 1;
      else begin @(negedge clk); i++; end
    end
  endtask

  // Commit the head and return when its completion pulse is visible.
  // lat = number of cycles after the commit cycle.
  task automatic run_commit(input logic [2:0] tag, output bit saw_ready, output bit saw_done,
                            output logic [31:0] val, output int lat);
    wait_ready(tag, saw_ready);
    ls_commit = 1'b1; ls_num = tag;
    @(negedge clk);
    ls_commit = 1'b0; ls_num = 3'd0;
    lat = 1; saw_done = 0; val = 32'd0;
    while (!saw_done && lat < 12) begin
      if (mem_num == tag) begin saw_done = 1; val = mem_value; end
      else begin @(negedge clk); lat++; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (lsb_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %0h want 0", lsb_full); end
    n_cmp++; if (ready_load_num !== 3'd0) begin n_bad++; $display("FAIL rst_ready: got %0h want 0", ready_load_num); end
    n_cmp++; if (mem_num !== 3'd0 || mem_value !== 32'd0) begin n_bad++; $display("FAIL rst_result: got %0h/%0h want 0/0", mem_num, mem_value); end
    n_cmp++; if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0) begin n_bad++; $display("FAIL rst_port: got a=%0h wr=%0h d=%0h want 0", mem_a, mem_wr, mem_dout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    bit ok;
    int wsz;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    wsz = wr_addr_q.size();
    dispatch(5'b11001, 32'h100, 32'h11223344, 3'd0, 3'd0, 32'd0, 3'd3);
    wait_ready(3'd3, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sw_ready: got %0h want 3", ready_load_num); end
    ls_commit = 1'b1; ls_num = 3'd3;
    @(negedge clk);
    ls_commit = 1'b0; ls_num = 3'd0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h100 + k || mem_dout !== exp_b[k] || mem_num !== 3'd0) begin
        n_bad++;
        $display("FAIL sw_byte%0d: got wr=%0h a=%0h d=%0h num=%0h want wr=1 a=%0h d=%0h num=0",
                 k, mem_wr, mem_a, mem_dout, mem_num, 32'h100 + k, exp_b[k]);
      end
      @(negedge clk);
    end
    n_cmp++; if (mem_num !== 3'd3 || mem_value !== 32'd0 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL sw_done_c5: got num=%0h val=%0h wr=%0h want 3/0/0", mem_num, mem_value, mem_wr); end
    @(negedge clk);
    n_cmp++; if (mem_num !== 3'd0) begin n_bad++; $display("FAIL sw_pulse_width: got %0h want 0", mem_num); end
    n_cmp++; if (wr_addr_q.size() != wsz + 4) begin n_bad++; $display("FAIL sw_wr_count: got %0d want %0d", wr_addr_q.size(), wsz + 4); end
  endtask

  task automatic test_load_byte;
    bit okr, okd;
    logic [31:0] v;
    int lat;
    dispatch(5'b10010, 32'h20, 32'd0, 3'd0, 3'd0, 32'd0, 3'd2);
    @(negedge clk);
    n_cmp++; if (ready_load_num !== 3'd2) begin n_bad++; $display("FAIL lb_ready: got %0h want 2", ready_load_num); end
    run_commit(3'd2, okr, okd, v, lat);
    n_cmp++; if (!okd || v !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_value: got %0h (done=%0d) want ffffff80", v, okd); end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
    @(negedge clk);
    dispatch(5'b10101, 32'h20, 32'd0, 3'd0, 3'd0, 32'd0, 3'd2);
    run_commit(3'd2, okr, okd, v, lat);
    n_cmp++; if (!okd || v !== 32'h00000080) begin n_bad++; $display("FAIL lbu_value: got %0h (done=%0d) want 80", v, okd); end
    @(negedge clk);
  endtask

  task automatic test_operand_snoop;
    logic [31:0] ea [4];
    dispatch(5'b10100, 32'hDEAD, 32'd0, 3'd5, 3'd0, 32'd8, 3'd4);
    n_cmp++; if (ready_load_num !== 3'd0) begin n_bad++; $display("FAIL lw_early1: got %0h want 0", ready_load_num); end
    @(negedge clk);
    n_cmp++; if (ready_load_num !== 3'd0) begin n_bad++; $display("FAIL lw_early2: got %0h want 0", ready_load_num); end
    alu_num = 3'd5; alu_value = 32'h40;
    @(negedge clk);
    alu_num = 3'd0; alu_value = 32'd0;
    n_cmp++; if (ready_load_num !== 3'd0) begin n_bad++; $display("FAIL lw_early3: got %0h want 0", ready_load_num); end
    @(negedge clk);
    n_cmp++; if (ready_load_num !== 3'd4) begin n_bad++; $display("FAIL lw_ready: got %0h want 4", ready_load_num); end
    ls_commit = 1'b1; ls_num = 3'd4;
    @(negedge clk);
    ls_commit = 1'b0; ls_num = 3'd0;
    ea[0] = 32'h48; ea[1] = 32'h49; ea[2] = 32'h4A; ea[3] = 32'h4B;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_a !== ea[k] || mem_wr !== 1'b0) begin
        n_bad++; $display("FAIL lw_addr%0d: got a=%0h wr=%0h want a=%0h wr=0", k, mem_a, mem_wr, ea[k]);
      end
      @(negedge clk);
    end
    n_cmp++; if (mem_num !== 3'd0 || mem_a !== 32'd0) begin n_bad++; $display("FAIL lw_c5: got num=%0h a=%0h want 0/0", mem_num, mem_a); end
    @(negedge clk);
    n_cmp++; if (mem_num !== 3'd4 || mem_value !== 32'hEFBEADDE) begin n_bad++; $display("FAIL lw_done_c6: got num=%0h val=%0h want 4/efbeadde", mem_num, mem_value); end
    @(negedge clk);
  endtask

  task automatic test_full_wrap;
    bit okr, okd, seen;
    logic [31:0] v;
    int lat;
    logic [2:0]  tags [4];
    logic [31:0] vals [4];
    dispatch(5'b10010, 32'd0, 32'd0, 3'd7, 3'd0, 32'h30, 3'd1);
    dispatch(5'b10010, 32'd0, 32'd0, 3'd7, 3'd0, 32'h31, 3'd2);
    n_cmp++; if (lsb_full !== 1'b0) begin n_bad++; $display("FAIL full_at2: got %0h want 0", lsb_full); end
    dispatch(5'b10010, 32'd0, 32'd0, 3'd7, 3'd0, 32'h32, 3'd3);
    n_cmp++; if (lsb_full !== 1'b1) begin n_bad++; $display("FAIL full_at3: got %0h want 1", lsb_full); end
    alu_num = 3'd7; alu_value = 32'd0;
    @(negedge clk);
    alu_num = 3'd0;
    run_commit(3'd1, okr, okd, v, lat);
    n_cmp++; if (!okd || v !== 32'h1) begin n_bad++; $display("FAIL fill_t1: got %0h (done=%0d) want 1", v, okd); end
    @(negedge clk);
    n_cmp++; if (lsb_full !== 1'b0) begin n_bad++; $display("FAIL full_after_deq: got %0h want 0", lsb_full); end
    dispatch(5'b10101, 32'h33, 32'd0, 3'd0, 3'd0, 32'd0, 3'd5);
    n_cmp++; if (lsb_full !== 1'b1) begin n_bad++; $display("FAIL full_refill: got %0h want 1", lsb_full); end
    dispatch(5'b10101, 32'h34, 32'd0, 3'd0, 3'd0, 32'd0, 3'd6);
    // Queue now holds four ops; this one must be dropped
    dispatch(5'b10010, 32'h20, 32'd0, 3'd0, 3'd0, 32'd0, 3'd7);
    tags[0] = 3'd2; tags[1] = 3'd3; tags[2] = 3'd5; tags[3] = 3'd6;
    vals[0] = 32'h2; vals[1] = 32'h3; vals[2] = 32'h4; vals[3] = 32'h5;
    for (int j = 0; j < 4; j++) begin
      run_commit(tags[j], okr, okd, v, lat);
      n_cmp++;
      if (!okd || v !== vals[j]) begin
        n_bad++; $display("FAIL drain_t%0d: got %0h (done=%0d) want %0h", tags[j], v, okd, vals[j]);
      end
      @(negedge clk);
    end
    seen = 0;
    repeat (8) begin
      if (ready_load_num != 3'd0) seen = 1;
      @(negedge clk);
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL drop_when_full: got ready seen=1 want 0"); end
  endtask

  task automatic test_reset_mid_access;
    bit ok, seen;
    int wsz;
    dispatch(5'b11001, 32'h200, 32'hAABBCCDD, 3'd0, 3'd0, 32'd0, 3'd3);
    dispatch(5'b10010, 32'h20, 32'd0, 3'd0, 3'd0, 32'd0, 3'd4);
    wait_ready(3'd3, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rsm_ready: got %0h want 3", ready_load_num); end
    wsz = wr_addr_q.size();
    ls_commit = 1'b1; ls_num = 3'd3;
    @(negedge clk);
    ls_commit = 1'b0; ls_num = 3'd0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_wr !== 1'b1 || mem_a !== 32'h202 || mem_dout !== 8'hBB) begin n_bad++; $display("FAIL rsm_byte2: got wr=%0h a=%0h d=%0h want 1/202/bb", mem_wr, mem_a, mem_dout); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 32'd0) begin n_bad++; $display("FAIL rsm_port: got wr=%0h a=%0h want 0/0", mem_wr, mem_a); end
    n_cmp++; if (mem_num !== 3'd0 || ready_load_num !== 3'd0 || lsb_full !== 1'b0) begin n_bad++; $display("FAIL rsm_state: got num=%0h rdy=%0h full=%0h want 0/0/0", mem_num, ready_load_num, lsb_full); end
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready_load_num != 3'd0 || mem_wr != 1'b0) seen = 1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rsm_flushed: got activity after reset want none"); end
    n_cmp++; if (wr_addr_q.size() != wsz + 3 || wr_data_q[wr_data_q.size()-1] !== 8'hBB) begin n_bad++; $display("FAIL rsm_writes: got %0d writes want %0d ending bb", wr_addr_q.size() - wsz, 3); end
  endtask

  task automatic test_misalign;
    bit ok;
    dispatch(5'b10011, 32'h100, 32'd0, 3'd0, 3'd0, 32'd1, 3'd6);
    wait_ready(3'd6, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL lh_ready: got %0h want 6", ready_load_num); end
    ls_commit = 1'b1; ls_num = 3'd6;
    @(negedge clk);
    ls_commit = 1'b0; ls_num = 3'd0;
`ifdef LSB_MISALIGN_CHECK_EN
    n_cmp++; if (mem_num !== 3'd6 || mem_value !== 32'd0 || misalign_err !== 1'b1 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL lh_misalign: got num=%0h val=%0h err=%0h wr=%0h want 6/0/1/0", mem_num, mem_value, misalign_err, mem_wr); end
    @(negedge clk);
    n_cmp++; if (misalign_err !== 1'b0 || mem_num !== 3'd0) begin n_bad++; $display("FAIL lh_err_pulse: got err=%0h num=%0h want 0/0", misalign_err, mem_num); end
`else
    n_cmp++; if (mem_a !== 32'h101 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL lh_addr0: got a=%0h wr=%0h want 101/0", mem_a, mem_wr); end
    @(negedge clk);
    n_cmp++; if (mem_a !== 32'h102) begin n_bad++; $display("FAIL lh_addr1: got a=%0h want 102", mem_a); end
    @(negedge clk);
    n_cmp++; if (mem_num !== 3'd0) begin n_bad++; $display("FAIL lh_c3: got num=%0h want 0", mem_num); end
    @(negedge clk);
    n_cmp++; if (mem_num !== 3'd6 || mem_value !== 32'hFFFF9234) begin n_bad++; $display("FAIL lh_done_c4: got num=%0h val=%0h want 6/ffff9234", mem_num, mem_value); end
`endif
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op_in = 5'h1F; value1_in = 32'd0; value2_in = 32'd0; imm_in = 32'd0;
    query1_in = 3'd0; query2_in = 3'd0; target_in = 3'd0; alu_num = 3'd0; alu_value = 32'd0;
    ls_commit = 1'b0; ls_num = 3'd0;
    @(negedge clk);
    test_reset();
    test_store_word();
    test_load_byte();
    test_operand_snoop();
    test_full_wrap();
    test_reset_mid_access();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
